display_source_mux: RTL

Registered, parametrised N-source display multiplexer that sits between the per-function display generators (set-time, current-time, temperature and later additions) and the board's 8-digit seven-segment drive pins. It selects one source's segment/digit-select/dot bundle by `mode`, and blanks the display for a programmable interval on every mode change so the outgoing source cannot ghost. It also applies a global PWM brightness gate and flags when a switch is in progress.

---
 rtl/display_source_mux.sv | 121 ++++++++++++
 1 files changed

// File: rtl/display_source_mux.sv
// Registered N-source seven-segment display multiplexer with blanking on mode
// change and a global PWM brightness gate.
module display_source_mux #(
    parameter int unsigned N            = 5,
    parameter int unsigned MODE_W       = 4,
    parameter int unsigned RESET_MODE   = 0,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned PWM_W        = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [MODE_W-1:0]   mode,
    input  logic [N*8-1:0]      seg_in,
    input  logic [N*8-1:0]      sel_in,
    input  logic [N-1:0]        dot_in,
    input  logic [PWM_W-1:0]    dim,
    output logic [7:0]          oout,
    output logic [7:0]          chs,
    output logic                dot,
    output logic                switching
);

    localparam int unsigned CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [MODE_W-1:0] MODE_RST = MODE_W'(RESET_MODE);

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [MODE_W-1:0]   active, active_nxt;
    logic [MODE_W-1:0]   pending, pending_nxt;
    logic [CNT_W-1:0]    blank_cnt, blank_cnt_nxt;
    logic [PWM_W-1:0]    pwm_cnt;
    logic                lit;
    logic [7:0]          seg_sel, chs_sel;
    logic                dot_sel;
    logic [7:0]          oout_nxt, chs_nxt;
    logic                dot_nxt, switching_nxt;

    // State, PWM counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SHOW;
            active    <= MODE_RST;
            pending   <= MODE_RST;
            blank_cnt <= '0;
            pwm_cnt   <= '0;
            oout      <= '0;
            chs       <= '0;
            dot       <= 1'b0;
            switching <= 1'b0;
        end else begin
            state     <= state_nxt;
            active    <= active_nxt;
            pending   <= pending_nxt;
            blank_cnt <= blank_cnt_nxt;
            pwm_cnt   <= pwm_cnt + PWM_W'(1);
            oout      <= oout_nxt;
            chs       <= chs_nxt;
            dot       <= dot_nxt;
            switching <= switching_nxt;
        end
    end

    // Next-state and output selection
    always_comb begin
        state_nxt     = state;
        active_nxt    = active;
        pending_nxt   = pending;
        blank_cnt_nxt = blank_cnt;
        oout_nxt      = '0;
        chs_nxt       = '0;
        dot_nxt       = 1'b0;
        switching_nxt = (state == BLANK);
        seg_sel       = '0;
        chs_sel       = '0;
        dot_sel       = 1'b0;

        // Out-of-range active index matches no source and stays dark
        for (int unsigned k = 0; k < N; k++) begin
            if (active == MODE_W'(k)) begin
                seg_sel = seg_in[8*k +: 8];
                chs_sel = sel_in[8*k +: 8];
                dot_sel = dot_in[k];
            end
        end

        lit = (dim == '1) || (pwm_cnt < dim);

        case (state)
            SHOW: begin
                if (lit) begin
                    oout_nxt = seg_sel;
                    chs_nxt  = chs_sel;
                    dot_nxt  = dot_sel;
                end
                if (mode != active) begin
                    pending_nxt   = mode;
                    blank_cnt_nxt = CNT_LOAD;
                    state_nxt     = BLANK;
                end
            end
            BLANK: begin
                if (mode != pending) begin
                    pending_nxt   = mode;
                    blank_cnt_nxt = CNT_LOAD;
                end else if (blank_cnt == '0) begin
                    active_nxt = pending;
                    state_nxt  = SHOW;
                end else begin
                    blank_cnt_nxt = blank_cnt - CNT_W'(1);
                end
            end
            default: state_nxt = SHOW;
        endcase
    end

endmodule
